// File: rtl/clm_inverse_sequencer_if.sv
// Operand, randomness and result handshakes of the CLM inverse sequencer.
// The master drives operands, randomness and out_ready; the slave is the sequencer.
interface clm_inverse_sequencer_if #(
   parameter int d = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [8+d-1:0] in_data;
   logic           rnd_valid;
   logic           rnd_ready;
   logic [d-1:0]   rnd_data;
   logic           out_valid;
   logic           out_ready;
   logic [8+d-1:0] out_data;
   logic           busy;

   modport master (
      output in_valid, in_data, rnd_valid, rnd_data, out_ready,
      input  in_ready, rnd_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, rnd_valid, rnd_data, out_ready,
      output in_ready, rnd_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/clm_inverse_sequencer.sv
// GF(2^8) inversion a^254 on CLM codewords via an 11-step addition chain over one shared multiplier.
// 11 cycles accept-to-result plus one per randomness stall; result held until out_ready.

module clm_multiplier #(
   parameter int               d     = 4,
   parameter logic [d:0]       Q     = 5'h13,
   parameter logic [d*(8+d)-1:0] B_ext = {12'h8D8, 12'h46C, 12'h236, 12'h11B}
) (
   input  logic [8+d-1:0] a_i,
   input  logic [8+d-1:0] b_i,
   input  logic [d-1:0]   r_i,
   output logic [8+d-1:0] y_o
);
   localparam int W = 8 + d;

   function automatic logic [W:0] calc_pq();
      logic [W:0] acc;
      acc = '0;
      for (int i = 0; i <= d; i++)
         if (Q[i]) acc ^= ({{d{1'b0}}, 9'h11B} << i);
      return acc;
   endfunction

   localparam logic [W:0] PQ = calc_pq();

   logic [2*W-1:0] prod;
   logic [W-1:0]   refresh;

   always_comb begin
      prod = '0;
      for (int i = 0; i < W; i++)
         if (b_i[i]) prod ^= ({{W{1'b0}}, a_i} << i);
      // Reduce mod P*Q so the result still reduces mod P to the field product.
      for (int i = 2*W-1; i >= W; i--)
         if (prod[i]) prod ^= ({{(W-1){1'b0}}, PQ} << (i - W));
      refresh = '0;
      for (int i = 0; i < d; i++)
         if (r_i[i]) refresh ^= B_ext[i*W +: W];
      y_o = prod[W-1:0] ^ refresh;
   end
endmodule

module clm_inverse_sequencer #(
   parameter int                 d     = 4,
   parameter logic [d*(8+d)-1:0] B_ext = {12'h8D8, 12'h46C, 12'h236, 12'h11B}
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   clm_inverse_sequencer_if.slave    bus
);
   localparam int W = 8 + d;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q;
   logic [3:0]     step_q;
   logic [3:0]     step_d;
   logic [W-1:0]   x_q, x2_q, x3_q, x12_q, x14_q, acc_q;
   logic [W-1:0]   out_data_q;
   logic           out_valid_q, in_ready_q, rnd_ready_q, busy_q;
   logic [W-1:0]   mul_a, mul_b, prod;

   assign bus.in_ready  = in_ready_q;
   assign bus.rnd_ready = rnd_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = busy_q;

   assign step_d = step_q + 4'd1;

   always_comb begin
      mul_a = acc_q;
      mul_b = acc_q;
      case (step_q)
         4'd0:    begin mul_a = x_q;   mul_b = x_q;   end
         4'd1:    begin mul_a = x2_q;  mul_b = x_q;   end
         4'd2:    begin mul_a = x3_q;  mul_b = x3_q;  end
         4'd4:    begin mul_a = x12_q; mul_b = x2_q;  end
         4'd5:    begin mul_a = x12_q; mul_b = x3_q;  end
         4'd10:   begin mul_a = acc_q; mul_b = x14_q; end
         default: begin mul_a = acc_q; mul_b = acc_q; end
      endcase
   end

   clm_multiplier #(.d(d), .B_ext(B_ext)) u_mul (
      .a_i (mul_a),
      .b_i (mul_b),
      .r_i (bus.rnd_data),
      .y_o (prod)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         step_q      <= 4'd0;
         x_q         <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
         x12_q       <= '0;
         x14_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         rnd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  state_q     <= S_RUN;
                  x_q         <= bus.in_data;
                  step_q      <= 4'd0;
                  in_ready_q  <= 1'b0;
                  rnd_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_RUN: begin
               // Without fresh randomness nothing moves, so no r is ever reused.
               if (bus.rnd_valid) begin
                  step_q <= step_d;
                  case (step_q)
                     4'd0:    x2_q  <= prod;
                     4'd1:    x3_q  <= prod;
                     4'd3:    x12_q <= prod;
                     4'd4:    x14_q <= prod;
                     default: acc_q <= prod;
                  endcase
                  if (step_q == 4'd10) begin
                     state_q     <= S_DONE;
                     step_q      <= 4'd0;
                     rnd_ready_q <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_data_q  <= prod;
                  end
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  x_q         <= '0;
                  x2_q        <= '0;
                  x3_q        <= '0;
                  x12_q       <= '0;
                  x14_q       <= '0;
                  acc_q       <= '0;
                  out_data_q  <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               rnd_ready_q <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end
endmodule
